atomrvcore_alu_issue: RTL and testbench

ATOMRVCORE_ALU_ISSUE -- requirements
Module: atomrvcore_alu_issue

---
 rtl/atomrvcore_alu_issue.sv | 251 +++++++++++++++++++++++++
 tb/tb_atomrvcore_alu_issue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomrvcore_alu_issue.sv
// atomrvcore_alu_issue
// Decodes an RV32I instruction beat into an ALU command (opcode, two operands,
// destination register, illegal flag) and issues it through a two-entry
// output/skid buffer with valid/ready handshakes on both sides.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   instr_valid_i/_ready_o    input handshake; instr_ready_o is registered
//   instr_i, pc_i             instruction word and its PC
//   rs1_data_i, rs2_data_i    register-file read data for instr_i
//   flush_i                   synchronous discard of all buffered beats
//   alu_valid_o/alu_ready_i   output handshake
//   ALUop_o, operand_A_o,
//   operand_B_o, rd_o,
//   illegal_o                 registered ALU command
//   issued_cnt_o              wrapping count of output transfers
module atomrvcore_alu_issue #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned OPCODE_WIDTH = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    input  logic [31:0]             instr_i,
    input  logic [DATAWIDTH-1:0]    pc_i,
    input  logic [DATAWIDTH-1:0]    rs1_data_i,
    input  logic [DATAWIDTH-1:0]    rs2_data_i,
    input  logic                    flush_i,
    output logic                    alu_valid_o,
    input  logic                    alu_ready_i,
    output logic [OPCODE_WIDTH-1:0] ALUop_o,
    output logic [DATAWIDTH-1:0]    operand_A_o,
    output logic [DATAWIDTH-1:0]    operand_B_o,
    output logic [4:0]              rd_o,
    output logic                    illegal_o,
    output logic [15:0]             issued_cnt_o
);

    localparam int unsigned CmdW = OPCODE_WIDTH + 2 * DATAWIDTH + 5 + 1;

    localparam logic [OPCODE_WIDTH-1:0] OpAdd  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OpSll  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OpSlt  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OpSltu = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OpXor  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OpSrl  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OpSra  = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OpOr   = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OpAnd  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OpSub  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OpBne  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OpBlt  = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OpBge  = OPCODE_WIDTH'(14);
    localparam logic [OPCODE_WIDTH-1:0] OpBltu = OPCODE_WIDTH'(15);
    localparam logic [OPCODE_WIDTH-1:0] OpBgeu = OPCODE_WIDTH'(16);
    localparam logic [OPCODE_WIDTH-1:0] OpJal  = OPCODE_WIDTH'(17);

    // ------------------------------------------------------------------
    // Combinational decode of the input beat
    // ------------------------------------------------------------------
    logic [6:0]              w_opc;
    logic [2:0]              w_f3;
    logic [6:0]              w_f7;
    logic [DATAWIDTH-1:0]    w_imm_i;
    logic [DATAWIDTH-1:0]    w_imm_u;
    logic [DATAWIDTH-1:0]    w_shamt;
    logic [DATAWIDTH-1:0]    w_link;
    logic [OPCODE_WIDTH-1:0] w_op;
    logic [DATAWIDTH-1:0]    w_a;
    logic [DATAWIDTH-1:0]    w_b;
    logic [4:0]              w_rd;
    logic                    w_ill;
    logic [CmdW-1:0]         w_cmd;

    assign w_opc   = instr_i[6:0];
    assign w_f3    = instr_i[14:12];
    assign w_f7    = instr_i[31:25];
    assign w_imm_i = DATAWIDTH'($signed(instr_i[31:20]));
    assign w_imm_u = DATAWIDTH'($signed({instr_i[31:12], 12'b0}));
    assign w_shamt = DATAWIDTH'(instr_i[24:20]);
    assign w_link  = pc_i + DATAWIDTH'(4);

    always_comb begin
        w_op  = '0;
        w_a   = '0;
        w_b   = '0;
        w_rd  = instr_i[11:7];
        w_ill = 1'b0;
        case (w_opc)
            7'b0110011: begin // R-type
                w_a = rs1_data_i;
                w_b = rs2_data_i;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_op = OpAdd;
                        3'b001:  w_op = OpSll;
                        3'b010:  w_op = OpSlt;
                        3'b011:  w_op = OpSltu;
                        3'b100:  w_op = OpXor;
                        3'b101:  w_op = OpSrl;
                        3'b110:  w_op = OpOr;
                        default: w_op = OpAnd;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_op = OpSub;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_op = OpSra;
                end else begin
                    w_ill = 1'b1;
                end
            end
            7'b0010011: begin // I-type ALU
                w_a = rs1_data_i;
                w_b = w_imm_i;
                case (w_f3)
                    3'b000: w_op = OpAdd;
                    3'b010: w_op = OpSlt;
                    3'b011: w_op = OpSltu;
                    3'b100: w_op = OpXor;
                    3'b110: w_op = OpOr;
                    3'b111: w_op = OpAnd;
                    3'b001: begin
                        w_b = w_shamt;
                        if (w_f7 == 7'b0000000) w_op = OpSll;
                        else                    w_ill = 1'b1;
                    end
                    default: begin // 3'b101
                        w_b = w_shamt;
                        if (w_f7 == 7'b0000000)      w_op = OpSrl;
                        else if (w_f7 == 7'b0100000) w_op = OpSra;
                        else                         w_ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin // LUI
                w_op = OpAdd;
                w_b  = w_imm_u;
            end
            7'b0010111: begin // AUIPC
                w_op = OpAdd;
                w_a  = pc_i;
                w_b  = w_imm_u;
            end
            7'b1101111: begin // JAL
                w_op = OpJal;
                w_a  = w_link;
            end
            7'b1100111: begin // JALR
                w_op  = OpJal;
                w_a   = w_link;
                w_ill = (w_f3 != 3'b000);
            end
            7'b1100011: begin // branches
                w_a  = rs1_data_i;
                w_b  = rs2_data_i;
                w_rd = 5'd0;
                case (w_f3)
                    3'b000:  w_op = OpBeq;
                    3'b001:  w_op = OpBne;
                    3'b100:  w_op = OpBlt;
                    3'b101:  w_op = OpBge;
                    3'b110:  w_op = OpBltu;
                    3'b111:  w_op = OpBgeu;
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
        // Undecodable beats still flow, but carry an all-zero payload.
        if (w_ill) begin
            w_op = '0;
            w_a  = '0;
            w_b  = '0;
            w_rd = '0;
        end
    end

    assign w_cmd = {w_op, w_a, w_b, w_rd, w_ill};

    // ------------------------------------------------------------------
    // Two-entry buffer: r_out drives the outputs, r_skid absorbs the beat
    // accepted while r_out is stalled.
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic            r_skid_valid;
    logic            r_ready;
    logic [CmdW-1:0] r_out;
    logic [CmdW-1:0] r_skid;
    logic [15:0]     r_cnt;

    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_out_valid_d;
    logic            w_skid_valid_d;
    logic [CmdW-1:0] w_out_d;
    logic [CmdW-1:0] w_skid_d;

    assign w_in_xfer  = instr_valid_i && r_ready;
    assign w_out_xfer = r_out_valid && alu_ready_i;

    always_comb begin
        w_out_valid_d  = r_out_valid;
        w_out_d        = r_out;
        w_skid_valid_d = r_skid_valid;
        w_skid_d       = r_skid;
        if (flush_i) begin
            w_out_valid_d  = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (!r_out_valid || w_out_xfer) begin
            // Output slot frees up: skid has priority to keep order. While the
            // skid is full r_ready is low, so no input beat can collide here.
            if (r_skid_valid) begin
                w_out_valid_d  = 1'b1;
                w_out_d        = r_skid;
                w_skid_valid_d = 1'b0;
            end else begin
                w_out_valid_d = w_in_xfer;
                if (w_in_xfer) w_out_d = w_cmd;
            end
        end else if (w_in_xfer) begin
            w_skid_valid_d = 1'b1;
            w_skid_d       = w_cmd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
            r_cnt        <= '0;
        end else begin
            r_out_valid  <= w_out_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_ready      <= !w_skid_valid_d;
            r_out        <= w_out_d;
            r_skid       <= w_skid_d;
            if (w_out_xfer) r_cnt <= r_cnt + 16'd1;
        end
    end

    assign instr_ready_o = r_ready;
    assign alu_valid_o   = r_out_valid;
    assign issued_cnt_o  = r_cnt;
    assign {ALUop_o, operand_A_o, operand_B_o, rd_o, illegal_o} = r_out;

endmodule

// File: tb/tb_atomrvcore_alu_issue.sv
`timescale 1ns/1ps
module tb_atomrvcore_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic [5:0]  ALUop_o;
    logic [31:0] operand_A_o;
    logic [31:0] operand_B_o;
    logic [4:0]  rd_o;
    logic        illegal_o;
    logic [15:0] issued_cnt_o;

    atomrvcore_alu_issue #(
        .DATAWIDTH   (32),
        .OPCODE_WIDTH(6)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .flush_i      (flush_i),
        .alu_valid_o  (alu_valid_o),
        .alu_ready_i  (alu_ready_i),
        .ALUop_o      (ALUop_o),
        .operand_A_o  (operand_A_o),
        .operand_B_o  (operand_B_o),
        .rd_o         (rd_o),
        .illegal_o    (illegal_o),
        .issued_cnt_o (issued_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_value(input string tag, input logic [75:0] obs, input logic [75:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference decode: {op[5:0], A[31:0], B[31:0], rd[4:0], illegal}
    function automatic logic [75:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [5:0]  op;
        logic [31:0] oa;
        logic [31:0] ob;
        logic [4:0]  rd;
        logic        bad;
        f7 = ins[31:25];
        f3 = ins[14:12];
        op = 6'd0;
        oa = 32'd0;
        ob = 32'd0;
        rd = ins[11:7];
        bad = 1'b0;
        case (ins[6:0])
            7'h33: begin
                oa = a;
                ob = b;
                case ({f7, f3})
                    {7'h00, 3'd0}: op = 6'd1;
                    {7'h00, 3'd1}: op = 6'd2;
                    {7'h00, 3'd2}: op = 6'd3;
                    {7'h00, 3'd3}: op = 6'd4;
                    {7'h00, 3'd4}: op = 6'd5;
                    {7'h00, 3'd5}: op = 6'd6;
                    {7'h00, 3'd6}: op = 6'd8;
                    {7'h00, 3'd7}: op = 6'd9;
                    {7'h20, 3'd0}: op = 6'd10;
                    {7'h20, 3'd5}: op = 6'd7;
                    default:       bad = 1'b1;
                endcase
            end
            7'h13: begin
                oa = a;
                ob = {{20{ins[31]}}, ins[31:20]};
                case (f3)
                    3'd0: op = 6'd1;
                    3'd2: op = 6'd3;
                    3'd3: op = 6'd4;
                    3'd4: op = 6'd5;
                    3'd6: op = 6'd8;
                    3'd7: op = 6'd9;
                    3'd1: begin
                        ob = {27'd0, ins[24:20]};
                        if (f7 == 7'h00) op = 6'd2; else bad = 1'b1;
                    end
                    default: begin
                        ob = {27'd0, ins[24:20]};
                        if (f7 == 7'h00) op = 6'd6;
                        else if (f7 == 7'h20) op = 6'd7;
                        else bad = 1'b1;
                    end
                endcase
            end
            7'h37: begin op = 6'd1; ob = {ins[31:12], 12'h000}; end
            7'h17: begin op = 6'd1; oa = pc; ob = {ins[31:12], 12'h000}; end
            7'h6F: begin op = 6'd17; oa = pc + 32'd4; end
            7'h67: begin
                if (f3 == 3'd0) begin op = 6'd17; oa = pc + 32'd4; end
                else bad = 1'b1;
            end
            7'h63: begin
                oa = a;
                ob = b;
                rd = 5'd0;
                case (f3)
                    3'd0: op = 6'd11;
                    3'd1: op = 6'd12;
                    3'd4: op = 6'd13;
                    3'd5: op = 6'd14;
                    3'd6: op = 6'd15;
                    3'd7: op = 6'd16;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) return {6'd0, 32'd0, 32'd0, 5'd0, 1'b1};
        return {op, oa, ob, rd, 1'b0};
    endfunction

    // Scoreboard: push on accepted beat, pop on ALU transfer.
    logic [75:0] sb_q[$];
    int          n_issued = 0;
    logic        exp_ready = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb_q.delete();
            exp_ready = 1'b0;
            n_issued  = 0;
        end else begin
            check_value("alu_valid", 76'(alu_valid_o), 76'(sb_q.size() != 0));
            check_value("instr_ready", 76'(instr_ready_o), 76'(exp_ready));
            check_value("issued_cnt", 76'(issued_cnt_o), 76'(n_issued[15:0]));
            if (alu_valid_o && sb_q.size() != 0) begin
                check_value("cmd", {ALUop_o, operand_A_o, operand_B_o, rd_o, illegal_o}, sb_q[0]);
                if (alu_ready_i) begin
                    void'(sb_q.pop_front());
                    n_issued++;
                end
            end
            if (flush_i) sb_q.delete();
            else if (instr_valid_i && instr_ready_o)
                sb_q.push_back(model(instr_i, pc_i, rs1_data_i, rs2_data_i));
            exp_ready = (sb_q.size() < 2);
        end
    end

    function automatic logic [75:0] out_vec();
        return {ALUop_o, operand_A_o, operand_B_o, rd_o, illegal_o};
    endfunction

    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
        int budget = 50;
        instr_valid_i = 1'b1;
        instr_i       = ins;
        pc_i          = pc;
        rs1_data_i    = a;
        rs2_data_i    = b;
        while (!instr_ready_o && budget > 0) begin
            @(posedge clk_i); #1;
            budget--;
        end
        if (budget == 0) check_value("send_timeout", 76'd0, 76'd1);
        @(posedge clk_i); #1;
        instr_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int i = 0;
        while (sb_q.size() != 0 && i < 50) begin
            @(posedge clk_i); #1;
            i++;
        end
        if (sb_q.size() != 0) check_value("drain_timeout", 76'(sb_q.size()), 76'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] base;
        rst_ni        = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 32'd0;
        pc_i          = 32'd0;
        rs1_data_i    = 32'd0;
        rs2_data_i    = 32'd0;
        flush_i       = 1'b0;
        alu_ready_i   = 1'b1;
        #1;
        check_value("rst_outputs", out_vec(), 76'd0);
        check_value("rst_valid", 76'(alu_valid_o), 76'd0);
        check_value("rst_ready", 76'(instr_ready_o), 76'd0);
        check_value("rst_cnt", 76'(issued_cnt_o), 76'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_value("ready_low_after_rst", 76'(instr_ready_o), 76'd0);
        @(posedge clk_i); #1;
        check_value("ready_rise", 76'(instr_ready_o), 76'd1);

        // Directed decode vectors
        send(32'h00510093, 32'h0, 32'd10, 32'd0);
        check_value("addi", out_vec(), {6'b000001, 32'd10, 32'd5, 5'd1, 1'b0});
        send(32'h402081B3, 32'h4, 32'd7, 32'd9);
        check_value("sub", out_vec(), {6'b001010, 32'd7, 32'd9, 5'd3, 1'b0});
        send(32'h4030D093, 32'h8, 32'h80000000, 32'd0);
        check_value("srai", out_vec(), {6'b000111, 32'h80000000, 32'd3, 5'd1, 1'b0});
        send(32'h008000EF, 32'hFFFFFFFC, 32'd1, 32'd2);
        check_value("jal_wrap", out_vec(), {6'b010001, 32'd0, 32'd0, 5'd1, 1'b0});
        send(32'hFFFFFFFF, 32'h10, 32'd3, 32'd4);
        check_value("illegal", out_vec(), {6'd0, 32'd0, 32'd0, 5'd0, 1'b1});
        wait_drain();

        // Back-pressure: 3 beats offered, 2 held
        alu_ready_i = 1'b0;
        send(32'h00A00113, 32'h20, 32'd0, 32'd0);   // addi x2,x0,10
        send(32'h00209463, 32'h24, 32'd5, 32'd6);   // bne x1,x2
        check_value("bp_ready_low", 76'(instr_ready_o), 76'd0);
        instr_valid_i = 1'b1;
        instr_i       = 32'h123452B7;               // lui x5
        repeat (3) @(posedge clk_i);
        #1;
        check_value("bp_still_full", 76'(instr_ready_o), 76'd0);
        check_value("bp_held_valid", 76'(alu_valid_o), 76'd1);
        check_value("bp_held_cmd", out_vec(), {6'b000001, 32'd0, 32'd10, 5'd2, 1'b0});
        base = issued_cnt_o;
        alu_ready_i = 1'b1;
        send(32'h123452B7, 32'h28, 32'd0, 32'd0);
        wait_drain();
        check_value("bp_cnt_plus3", 76'(issued_cnt_o), 76'(base + 16'd3));

        // Flush with one held entry, a live output transfer and a dropped input
        send(32'h00100093, 32'h30, 32'd0, 32'd0);
        flush_i       = 1'b1;
        instr_valid_i = 1'b1;
        instr_i       = 32'h00200093;
        @(posedge clk_i); #1;
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        check_value("flush1_valid", 76'(alu_valid_o), 76'd0);
        @(posedge clk_i); #1;
        check_value("flush1_dropped", 76'(alu_valid_o), 76'd0);

        // Flush with both entries full
        alu_ready_i = 1'b0;
        send(32'h00100093, 32'h40, 32'd0, 32'd0);
        send(32'h00200113, 32'h44, 32'd0, 32'd0);
        check_value("flush2_full", 76'(instr_ready_o), 76'd0);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check_value("flush2_valid", 76'(alu_valid_o), 76'd0);
        check_value("flush2_ready", 76'(instr_ready_o), 76'd1);
        alu_ready_i = 1'b1;

        // Stream random beats back to back until 0xFFFF transfers total
        for (int c = 0; c < 70000 && (n_issued + sb_q.size()) < 65535; c++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0: instr_i = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r[24:7], 7'h33};
                1: instr_i = {r[31:7], 7'h13};
                2: instr_i = {r[31:7], 7'h63};
                3: instr_i = {r[31:7], ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
                default: instr_i = r;
            endcase
            pc_i          = $urandom();
            rs1_data_i    = $urandom();
            rs2_data_i    = $urandom();
            instr_valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        instr_valid_i = 1'b0;
        wait_drain();
        check_value("cnt_ffff", 76'(issued_cnt_o), 76'h0FFFF);
        send(32'h00510093, 32'h0, 32'd1, 32'd0);
        wait_drain();
        check_value("cnt_wrap", 76'(issued_cnt_o), 76'd0);

        // Asynchronous reset in the middle of a held stream
        alu_ready_i = 1'b0;
        send(32'h00510093, 32'h50, 32'd1, 32'd0);
        send(32'h402081B3, 32'h54, 32'd2, 32'd3);
        #2 rst_ni = 1'b0;
        #1;
        check_value("midrst_outputs", out_vec(), 76'd0);
        check_value("midrst_valid", 76'(alu_valid_o), 76'd0);
        check_value("midrst_ready", 76'(instr_ready_o), 76'd0);
        check_value("midrst_cnt", 76'(issued_cnt_o), 76'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        alu_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check_value("postrst_ready", 76'(instr_ready_o), 76'd1);
        check_value("postrst_valid", 76'(alu_valid_o), 76'd0);
        repeat (2) @(posedge clk_i);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
